if_de_skid: RTL and testbench
=============================

Name: if_de_skid

Overview:
Fetch/Decode pipeline register with a 2-entry skid buffer. It sits between the instruction fetch stage and the decoder, which feeds the decode/execute register. It carries PC, PC+4 and the fetched instruction. It decouples fetch from decode back-pressure with a valid/ready handshake and supports branch flush. Whenever the held entry is not valid, the instruction output shows a NOP, so decode sees a bubble.

Parameters:
XLEN, 32, width of PC and PC+4 fields
INST_W, 32, instruction width
NOP_INST, 32'h00000013, instruction driven on instOut when out_valid=0 (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
PCIn  input  XLEN  PC of fetched instruction
incrementPCIn  input  XLEN  PC+4 from fetch
instIn  input  INST_W  fetched instruction
in_valid  input  1  fetch has a valid instruction
in_ready  output  1  block can accept this cycle
flush  input  1  branch/jump taken; discard all held and incoming entries
PCOut  output  XLEN  PC to decode
incrementPCOut  output  XLEN  PC+4 to decode
instOut  output  INST_W  instruction to decode; NOP_INST when out_valid=0
out_valid  output  1  main entry valid
out_ready  input  1  decode/DE-EX stage accepts this cycle

Behaviour:
- Storage: main entry {valid, PC, PC+4, inst} drives all outputs; skid entry has the same fields.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = ~skid_valid. It depends only on registered state; there is no combinational path from out_ready or in_valid.
- out_valid = main_valid. instOut = main_valid ? main_inst : NOP_INST. PCOut and incrementPCOut show the main data registers regardless of valid.
- Latency: an accepted entry appears on the outputs on the next rising edge (1 cycle) when main is empty or draining.
- Update on each rising edge, in priority order:
  1. rst_n=0: main_valid=0, skid_valid=0, all data regs cleared to 0. Result: out_valid=0, instOut=NOP_INST, PCOut=0, incrementPCOut=0, in_ready=1 from the first cycle after reset.
  2. flush=1: main_valid=0, skid_valid=0. Any entry accepted in the same cycle is discarded. Data regs hold. in_ready=1 next cycle.
  3. Main empty or drain: main loads skid if skid_valid and skid_valid clears; otherwise main loads the input if accept; otherwise main_valid=0.
  4. Main valid, no drain, accept: input loads into skid and skid_valid=1.
  5. Main valid, no drain, no accept: hold.
- Order is preserved: the skid entry always moves to main before any newer input. When skid is full, accept is impossible because in_ready=0.
- Full condition (main and skid both valid): in_ready=0. A drain moves skid to main; in_ready returns to 1 the next cycle.
- Empty condition: out_valid=0, instOut=NOP_INST, and out_ready is ignored.
- Simultaneous drain and accept with skid empty: main takes the input; throughput is 1 per cycle.
- Reset mid-operation: all in-flight entries are lost and no partial state survives.
- Flush and drain in the same cycle: the drain completes downstream, then main is invalidated.

Optional Feature:
IF_DE_SKID_PERF_EN
- Defined: adds two outputs, stallCount [31:0] and flushCount [31:0], both cleared by rst_n=0.
  - stallCount increments each cycle with in_valid=1 and in_ready=0.
  - flushCount increments each cycle with flush=1 and (main_valid or skid_valid).
  - Both wrap at 2^32-1 -> 0. Flush does not clear them.
- Not defined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 -> out_valid=0, instOut=32'h00000013, PCOut=0, in_ready=1.
- Streaming: out_ready=1; present PC 0x00,0x04,0x08 with insts 0x00500093,0x00A00113,0x002081B3 on consecutive cycles -> each appears on the outputs 1 cycle later, one per cycle, no bubbles.
- Back-pressure: hold out_ready=0 while pushing PC 0x10 then 0x14 -> out shows 0x10; 0x14 is held in skid; in_ready=0 and a third entry (0x18) is not accepted. Raise out_ready -> 0x10, 0x14, 0x18 appear in order, with in_ready=1 one cycle after the first drain.
- Flush: with both entries full (0x20, 0x24) and in_valid=1 for 0x28, assert flush for 1 cycle -> next cycle out_valid=0, instOut=NOP, in_ready=1; 0x28 is absent. A new entry at 0x100 then appears 1 cycle after acceptance.
- Reset mid-stream: both entries valid, rst_n=0 for 1 cycle -> out_valid=0, in_ready=1, PCOut=0.
- IF_DE_SKID_PERF_EN: 3 stall cycles plus 1 flush with an occupied buffer -> stallCount=3, flushCount=1. A flush with an empty buffer leaves flushCount=1.

Source files
------------

// File: rtl/if_de_skid.sv
// Fetch/Decode pipeline register with a 2-entry skid buffer and branch flush.
// Optional IF_DE_SKID_PERF_EN adds stallCount/flushCount performance counters.
module if_de_skid #(
    parameter int                 XLEN     = 32,
    parameter int                 INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   PCIn,
    input  logic [XLEN-1:0]   incrementPCIn,
    input  logic [INST_W-1:0] instIn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [XLEN-1:0]   PCOut,
    output logic [XLEN-1:0]   incrementPCOut,
    output logic [INST_W-1:0] instOut,
    output logic              out_valid,
    input  logic              out_ready
`ifdef IF_DE_SKID_PERF_EN
    ,
    output logic [31:0]       stallCount,
    output logic [31:0]       flushCount
`endif
);

    logic              main_valid_q, main_valid_d;
    logic [XLEN-1:0]   main_pc_q, main_pc_d;
    logic [XLEN-1:0]   main_pc4_q, main_pc4_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d;

    logic              skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
    logic [XLEN-1:0]   skid_pc4_q, skid_pc4_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;

    logic accept;
    logic drain;

    // Ready comes only from registered state so no comb path back to fetch.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid_q & out_ready;

    assign out_valid      = main_valid_q;
    assign PCOut          = main_pc_q;
    assign incrementPCOut = main_pc4_q;
    assign instOut        = main_valid_q ? main_inst_q : NOP_INST;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_pc4_d   = main_pc4_q;
        main_inst_d  = main_inst_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;
        skid_inst_d  = skid_inst_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            // Skid entry is older than anything on the input, so it goes first.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_pc_d    = skid_pc_q;
                main_pc4_d   = skid_pc4_q;
                main_inst_d  = skid_inst_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_pc_d    = PCIn;
                main_pc4_d   = incrementPCIn;
                main_inst_d  = instIn;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = PCIn;
            skid_pc4_d   = incrementPCIn;
            skid_inst_d  = instIn;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_pc_q    <= '0;
            main_pc4_q   <= '0;
            main_inst_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
            skid_inst_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_pc_q    <= main_pc_d;
            main_pc4_q   <= main_pc4_d;
            main_inst_q  <= main_inst_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_inst_q  <= skid_inst_d;
        end
    end

`ifdef IF_DE_SKID_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            // Only flushes that actually discard something are counted.
            if (flush && (main_valid_q || skid_valid_q)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_de_skid.sv
// Directed self-checking bench for if_de_skid (perf counters checked when IF_DE_SKID_PERF_EN is defined).
module tb_if_de_skid;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCIn, incrementPCIn, instIn;
    logic        in_valid, in_ready, flush;
    logic [31:0] PCOut, incrementPCOut, instOut;
    logic        out_valid, out_ready;
`ifdef IF_DE_SKID_PERF_EN
    logic [31:0] stallCount, flushCount;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    if_de_skid dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PCIn           (PCIn),
        .incrementPCIn  (incrementPCIn),
        .instIn         (instIn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .flush          (flush),
        .PCOut          (PCOut),
        .incrementPCOut (incrementPCOut),
        .instOut        (instOut),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
`ifdef IF_DE_SKID_PERF_EN
        ,
        .stallCount     (stallCount),
        .flushCount     (flushCount)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
        PCIn          = pc;
        incrementPCIn = pc + 32'd4;
        instIn        = inst;
        in_valid      = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, "_vld"},  {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"},   PCOut, pc);
        chk({tag, "_pc4"},  incrementPCOut, pc + 32'd4);
        chk({tag, "_inst"}, instOut, inst);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        PCIn = '0; incrementPCIn = '0; instIn = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_vld",   {31'd0, out_valid}, 32'd0);
        chk("rst_inst",  instOut, NOP);
        chk("rst_pc",    PCOut, 32'd0);
        chk("rst_pc4",   incrementPCOut, 32'd0);
        chk("rst_rdy",   {31'd0, in_ready}, 32'd1);

        // Streaming, one per cycle
        out_ready = 1'b1;
        drive(32'h00, 32'h00500093); tick(); chk_out("s0", 32'h00, 32'h00500093);
        drive(32'h04, 32'h00A00113); tick(); chk_out("s1", 32'h04, 32'h00A00113);
        drive(32'h08, 32'h002081B3); tick(); chk_out("s2", 32'h08, 32'h002081B3);
        in_valid = 1'b0; tick();
        chk("s_empty_vld",  {31'd0, out_valid}, 32'd0);
        chk("s_empty_inst", instOut, NOP);

        // Back-pressure
        out_ready = 1'b0;
        drive(32'h10, 32'h11111111); tick(); chk_out("bp0", 32'h10, 32'h11111111);
        chk("bp0_rdy", {31'd0, in_ready}, 32'd1);
        drive(32'h14, 32'h22222222); tick(); chk_out("bp1", 32'h10, 32'h11111111);
        chk("bp1_rdy", {31'd0, in_ready}, 32'd0);
        drive(32'h18, 32'h33333333); tick(); chk_out("bp2", 32'h10, 32'h11111111);
        chk("bp2_rdy", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1; tick();
        chk_out("bp3", 32'h14, 32'h22222222);
        chk("bp3_rdy", {31'd0, in_ready}, 32'd1);
        tick(); chk_out("bp4", 32'h18, 32'h33333333);
        in_valid = 1'b0; tick();
        chk("bp5_vld", {31'd0, out_valid}, 32'd0);

        // Flush with a full buffer
        out_ready = 1'b0;
        drive(32'h20, 32'h44444444); tick();
        drive(32'h24, 32'h55555555); tick();
        chk("fl_full_rdy", {31'd0, in_ready}, 32'd0);
        drive(32'h28, 32'h66666666); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_vld",  {31'd0, out_valid}, 32'd0);
        chk("fl_inst", instOut, NOP);
        chk("fl_rdy",  {31'd0, in_ready}, 32'd1);
        chk("fl_pc_hold", PCOut, 32'h20);
        tick();
        chk("fl_gone_vld", {31'd0, out_valid}, 32'd0);
        drive(32'h100, 32'h77777777); tick(); chk_out("fl_new", 32'h100, 32'h77777777);
        // Flush discards an entry accepted in the same cycle
        drive(32'h104, 32'h88888888); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fla_vld", {31'd0, out_valid}, 32'd0);
        chk("fla_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        chk("fla_gone", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream
        drive(32'h200, 32'h99999999); tick();
        drive(32'h204, 32'hAAAAAAAA); tick();
        chk("mr_full_rdy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0; in_valid = 1'b0; tick();
        rst_n = 1'b1;
        chk("mr_vld", {31'd0, out_valid}, 32'd0);
        chk("mr_rdy", {31'd0, in_ready}, 32'd1);
        chk("mr_pc",  PCOut, 32'd0);
        chk("mr_inst", instOut, NOP);
        tick();
        chk("mr_stay", {31'd0, out_valid}, 32'd0);

`ifdef IF_DE_SKID_PERF_EN
        chk("pf_rst_stall", stallCount, 32'd0);
        chk("pf_rst_flush", flushCount, 32'd0);
        drive(32'h300, 32'hBBBBBBBB); tick();
        drive(32'h304, 32'hCCCCCCCC); tick();
        drive(32'h308, 32'hDDDDDDDD);
        tick(); tick(); tick();
        in_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0;
        chk("pf_stall", stallCount, 32'd3);
        chk("pf_flush", flushCount, 32'd1);
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("pf_flush_empty", flushCount, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
